odo_sbox_small_seq: RTL and testbench

ODO_SBOX_SMALL_SEQ -- requirements
Module: odo_sbox_small_seq

---
 rtl/odo_sbox_small_seq.sv | 126 ++++++++++++
 tb/tb_odo_sbox_small_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/odo_sbox_small_seq.sv
// Sequential substitution of NFIELD 6-bit fields through one shared, externally
// registered 6-bit sbox. Fields are issued one per cycle and captured one cycle later.
module odo_sbox_small_seq #(
    parameter int unsigned NFIELD = 4,
    parameter int unsigned CNTW   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NFIELD-1:0]   in_data,
    output logic [5:0]            sbox_in,
    input  logic [5:0]            sbox_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NFIELD-1:0]   out_data,
    output logic [CNTW-1:0]       words_done
);

    localparam int unsigned IW = (NFIELD > 1) ? $clog2(NFIELD) : 1;
    localparam int unsigned W  = 6 * NFIELD;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   cap_idx_q, cap_idx_d;
    logic            cap_en_q, cap_en_d;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    res_q, res_d;
    logic [5:0]      sbox_in_q, sbox_in_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            last_issue;
    logic [IW-1:0]   idx_inc;
    logic [5:0]      next_field;

    always_comb begin
        idx_inc    = idx_q + IW'(1);
        last_issue = (idx_q == IW'(NFIELD - 1));
        next_field = '0;
        for (int i = 0; i < NFIELD; i++) begin
            if (idx_inc == IW'(i)) next_field = word_q[6*i +: 6];
        end
    end

    // Capture lags issue by one cycle: cap_idx_q names the field whose sbox result
    // is on sbox_out this cycle.
    always_comb begin
        res_d = res_q;
        if (cap_en_q) begin
            for (int i = 0; i < NFIELD; i++) begin
                if (cap_idx_q == IW'(i)) res_d[6*i +: 6] = sbox_out;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        sbox_in_d = 6'h00;
        cap_en_d  = 1'b0;
        cap_idx_d = cap_idx_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d   = StIssue;
                    idx_d     = '0;
                    word_d    = in_data;
                    sbox_in_d = in_data[5:0];
                end
            end
            StIssue: begin
                cap_en_d  = 1'b1;
                cap_idx_d = idx_q;
                if (last_issue) begin
                    state_d = StDrain;
                end else begin
                    idx_d     = idx_inc;
                    sbox_in_d = next_field;
                end
            end
            StDrain: begin
                state_d = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = cnt_q + CNTW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            word_q    <= '0;
            res_q     <= '0;
            sbox_in_q <= 6'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_idx_q <= cap_idx_d;
            cap_en_q  <= cap_en_d;
            word_q    <= word_d;
            res_q     <= res_d;
            sbox_in_q <= sbox_in_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StHold);
    assign out_data   = res_q;
    assign sbox_in    = sbox_in_q;
    assign words_done = cnt_q;

endmodule

// File: tb/tb_odo_sbox_small_seq.sv
// Directed bench for odo_sbox_small_seq with a registered sbox model; a second
// instance with a 3-bit counter shares the stimulus to exercise counter wrap.
module tb_odo_sbox_small_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic [5:0]  sbox_in;
    logic [5:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [15:0] words_done;

    logic        w_in_ready;
    logic [5:0]  w_sbox_in;
    logic [5:0]  w_sbox_out;
    logic        w_out_valid;
    logic [23:0] w_out_data;
    logic [2:0]  w_words_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Entries of odo_sbox_small23 used by the vectors below.
    function automatic logic [5:0] sbox_f(input logic [5:0] a);
        case (a)
            6'h00:   return 6'h0C;
            6'h01:   return 6'h06;
            6'h02:   return 6'h2F;
            6'h03:   return 6'h34;
            6'h3F:   return 6'h35;
            default: return a ^ 6'h2A;
        endcase
    endfunction

    always @(posedge clk) begin
        sbox_out   <= sbox_f(sbox_in);
        w_sbox_out <= sbox_f(w_sbox_in);
    end

    odo_sbox_small_seq #(.NFIELD(4), .CNTW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .words_done (words_done)
    );

    odo_sbox_small_seq #(.NFIELD(4), .CNTW(3)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .in_data    (in_data),
        .sbox_in    (w_sbox_in),
        .sbox_out   (w_sbox_out),
        .out_valid  (w_out_valid),
        .out_ready  (out_ready),
        .out_data   (w_out_data),
        .words_done (w_words_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 24'h0;
        out_ready = 1'b0;

        // Reset values
        #3;
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, 24'h0);
        chk("rst sbox_in", sbox_in, 6'h00);
        chk("rst words_done", words_done, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word A with out_ready held high
        out_ready = 1'b1;
        in_data   = 24'h0C2040;
        in_valid  = 1'b1;
        chk("A in_ready before accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("A sbox_in f0", sbox_in, 6'h00);
        tick();
        chk("A sbox_in f1", sbox_in, 6'h01);
        tick();
        chk("A sbox_in f2", sbox_in, 6'h02);
        tick();
        chk("A sbox_in f3", sbox_in, 6'h03);
        chk("A in_ready issue", in_ready, 1'b0);
        tick();
        chk("A sbox_in drain", sbox_in, 6'h00);
        chk("A out_valid drain", out_valid, 1'b0);
        tick();
        chk("A out_valid hold", out_valid, 1'b1);
        chk("A out_data", out_data, 24'hD2F18C);
        chk("A in_ready hold", in_ready, 1'b0);
        tick();
        chk("A out_valid after hs", out_valid, 1'b0);
        chk("A in_ready after hs", in_ready, 1'b1);
        chk("A words_done", words_done, 16'd1);

        // Word FFFFFF with backpressure in HOLD
        out_ready = 1'b0;
        in_data   = 24'hFFFFFF;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("F sbox_in f0", sbox_in, 6'h3F);
        tick();
        chk("F sbox_in f1", sbox_in, 6'h3F);
        tick();
        chk("F sbox_in f2", sbox_in, 6'h3F);
        tick();
        chk("F sbox_in f3", sbox_in, 6'h3F);
        tick();
        chk("F sbox_in drain", sbox_in, 6'h00);
        tick();
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = 24'h123456;
            chk("F out_valid stall", out_valid, 1'b1);
            chk("F out_data stall", out_data, 24'hD75D75);
            chk("F in_ready stall", in_ready, 1'b0);
            chk("F sbox_in hold", sbox_in, 6'h00);
            tick();
        end
        in_valid = 1'b0;
        chk("F out_data before hs", out_data, 24'hD75D75);
        chk("F words_done before hs", words_done, 16'd1);
        out_ready = 1'b1;
        tick();
        chk("F out_valid after hs", out_valid, 1'b0);
        chk("F words_done", words_done, 16'd2);
        out_ready = 1'b0;
        tick();
        chk("F single hs words_done", words_done, 16'd2);
        chk("F in_ready idle", in_ready, 1'b1);

        // Reset mid-word while issuing field 2
        in_data  = 24'hFFFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("R sbox_in idx2", sbox_in, 6'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("R in_ready", in_ready, 1'b1);
        chk("R out_valid", out_valid, 1'b0);
        chk("R out_data", out_data, 24'h0);
        chk("R sbox_in", sbox_in, 6'h00);
        chk("R words_done", words_done, 16'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_data   = 24'h0C2040;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("R out_valid early", out_valid, 1'b0);
        tick();
        chk("R out_valid", out_valid, 1'b1);
        chk("R out_data fresh", out_data, 24'hD2F18C);
        tick();
        chk("R words_done", words_done, 16'd1);

        // Back-to-back words, one accept every 7 cycles
        in_data   = 24'h0C2040;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            tick();
            chk("B in_ready", in_ready, (k % 7 == 0));
            chk("B out_valid", out_valid, (k % 7 == 6));
            if (k % 7 == 6) begin
                chk("B out_data", out_data, 24'hD2F18C);
                chk("B w_out_data", w_out_data, 24'hD2F18C);
            end
            if (k == 49) chk("B small counter wrap", w_words_done, 3'd0);
        end
        in_valid = 1'b0;
        chk("B words_done", words_done, 16'd10);
        chk("B small words_done", w_words_done, 3'd2);
        chk("B w_in_ready", w_in_ready, 1'b1);
        chk("B w_out_valid", w_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
